// File: rtl/div_unit_32_bit.sv
// Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU). Radix-2 restoring
// shift/subtract, one quotient bit per cycle, then a sign-fix cycle.
module div_unit_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIX_NEG   = CW'(WIDTH);

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [1:0]       op_r;
  logic             neg_q_r;
  logic             neg_rem_r;
  logic             pend_r;

  logic             signed_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic             div_zero_s;
  logic             ovf_s;
  logic [WIDTH-1:0] special_res_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;

  // Operand decode at accept: magnitudes, signs and the special-case result
  always_comb begin
    signed_s      = ~op[0];
    a_neg_s       = signed_s & dividend[WIDTH-1];
    b_neg_s       = signed_s & divisor[WIDTH-1];
    a_mag_s       = a_neg_s ? (ZERO - dividend) : dividend;
    b_mag_s       = b_neg_s ? (ZERO - divisor) : divisor;
    div_zero_s    = (divisor == ZERO);
    ovf_s         = signed_s && (dividend == INT_MIN) && (divisor == ONES);
    special_res_s = ZERO;
    if (div_zero_s) begin
      special_res_s = op[1] ? dividend : ONES;
    end else if (ovf_s) begin
      special_res_s = op[1] ? ZERO : INT_MIN;
    end else begin
      special_res_s = ZERO;
    end
  end

  // One restoring step; the partial remainder is widened by a bit so a
  // divisor above 2^(WIDTH-1) cannot lose the shifted-out MSB.
  always_comb begin
    shifted_s = {rem_r, q_r[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvsr_r};
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      q_r       <= ZERO;
      rem_r     <= ZERO;
      dvsr_r    <= ZERO;
      op_r      <= 2'b00;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      pend_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= ZERO;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          // A special-case result decided last edge is published now; a new
          // start in the same cycle may still be accepted alongside it.
          if (pend_r) begin
            result <= q_r;
            done   <= 1'b1;
            pend_r <= 1'b0;
          end
          if (start) begin
            op_r <= op;
            if (div_zero_s || ovf_s) begin
              q_r    <= special_res_s;
              pend_r <= 1'b1;
            end else begin
              q_r       <= a_mag_s;
              rem_r     <= ZERO;
              dvsr_r    <= b_mag_s;
              neg_q_r   <= a_neg_s ^ b_neg_s;
              neg_rem_r <= a_neg_s;
              cnt_r     <= {CW{1'b0}};
              busy      <= 1'b1;
              state_r   <= CALC;
            end
          end
        end
        CALC: begin
          if (!diff_s[WIDTH]) begin
            rem_r <= diff_s[WIDTH-1:0];
            q_r   <= {q_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= shifted_s[WIDTH-1:0];
            q_r   <= {q_r[WIDTH-2:0], 1'b0};
          end
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_ITER) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          if (cnt_r == FIX_NEG) begin
            q_r   <= neg_q_r ? (ZERO - q_r) : q_r;
            rem_r <= neg_rem_r ? (ZERO - rem_r) : rem_r;
            cnt_r <= cnt_r + CW'(1);
          end else begin
            result  <= op_r[1] ? rem_r : q_r;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit_32_bit.sv
// Self-checking bench for div_unit_32_bit: directed cases from the RV32M
// rules plus randomized operands against an arithmetic reference model.
module tb_div_unit_32_bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  div_unit_32_bit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension divide semantics using plain arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Called #1 after the accept edge: counts edges until done (bounded)
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat, busy_n, exp_lat;
    logic [31:0] exp;
    exp = ref_div(o, a, b);
    exp_lat = is_special(o, a, b) ? 1 : 34;
    issue(o, a, b);
    wait_done(lat, busy_n);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp);
    check({tag, " busy cycles"}, busy_n, (exp_lat == 1) ? 0 : 34);
    check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    check({tag, " result held"}, result, exp);
  endtask

  initial begin
    int lat, busy_n, done_cnt;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op("divu 100/7", OP_DIVU, 32'd100, 32'd7);
    do_op("remu 100/7", OP_REMU, 32'd100, 32'd7);
    do_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    do_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2);
    do_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE);
    do_op("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE);
    do_op("div by 0", OP_DIV, 32'h1234_5678, 32'd0);
    do_op("remu by 0", OP_REMU, 32'h1234_5678, 32'd0);
    do_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu min/-1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("remu min/-1", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu big divisor", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("remu big divisor", OP_REMU, 32'hFFFF_FFFD, 32'h8000_0001);

    // Reset mid-operation aborts with no done pulse
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("midrst no done", done_cnt, 0);
    check("midrst busy after", {31'd0, busy}, 32'd0);
    do_op("divu after rst", OP_DIVU, 32'hFFFF_FFFF, 32'h10);

    // Start while busy is ignored
    issue(OP_DIVU, 32'd1000, 32'd10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_REMU; dividend = 32'd7; divisor = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, busy_n);
    check("ignore latency", lat + 5, 34);
    check("ignore result", result, 32'd100);

    // Back-to-back: start raised during the done cycle
    @(posedge clk); #1;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat, busy_n);
    check("b2b first result", result, 32'd14);
    start = 1'b1; op = OP_REMU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b done drops", {31'd0, done}, 32'd0);
    check("b2b busy", {31'd0, busy}, 32'd1);
    wait_done(lat, busy_n);
    check("b2b latency", lat, 34);
    check("b2b result", result, 32'd2);
    @(posedge clk); #1;

    // Randomized operands, with occasional corner values
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 16));
        3: rb = rb >> $urandom_range(8, 30);
        4: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op($sformatf("rand%0d op%0d %08h/%08h", i, ro, ra, rb), ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
